// File: rtl/fft_output_reorder.sv
// Output reorder buffer for the final FFT stage: bit-reversed butterfly pairs are
// written into ping-pong RAM banks and read back in natural bin order through a 2-entry FIFO.
module fft_output_reorder #(
    parameter int LOG2N = 10,
    parameter int DW    = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_valid_in,
    input  logic [DW-1:0] i_data_a_real,
    input  logic [DW-1:0] i_data_a_imag,
    input  logic [DW-1:0] i_data_b_real,
    input  logic [DW-1:0] i_data_b_imag,
    input  logic          i_ready,
    output logic          o_valid_out,
    output logic [DW-1:0] o_data_a_real,
    output logic [DW-1:0] o_data_a_imag,
    output logic [DW-1:0] o_data_b_real,
    output logic [DW-1:0] o_data_b_imag,
    output logic          o_sof,
    output logic          o_eof,
    output logic          o_overflow
);

    localparam int AW = LOG2N - 1;
    localparam int N  = 1 << LOG2N;
    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } rd_state_e;

    // Bank select is the address MSB, so each RAM holds both banks.
    logic [2*DW-1:0] mem_lo [N];
    logic [2*DW-1:0] mem_hi [N];

    logic [2*DW-1:0] fifo_lo [2];
    logic [2*DW-1:0] fifo_hi [2];
    logic [1:0]      fifo_sof;
    logic [1:0]      fifo_eof;

    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic          wr_bank_q, wr_bank_d;
    logic          discard_q, discard_d;
    logic          overflow_q, overflow_d;
    logic [1:0]    full_q, full_d;

    rd_state_e     state_q, state_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic          rd_bank_q, rd_bank_d;

    logic [1:0]    fifo_cnt_q, fifo_cnt_d;
    logic          fifo_wptr_q, fifo_wptr_d;
    logic          fifo_rptr_q, fifo_rptr_d;

    logic             wr_en;
    logic             wr_frame_done;
    logic             discard_now;
    logic [LOG2N-1:0] wr_addr;
    logic [LOG2N-1:0] rd_addr;
    logic             rd_issue;
    logic             rd_last;
    logic             fifo_room;
    logic             fifo_pop;

    function automatic logic [AW-1:0] bit_reverse(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = v[AW-1-i];
        end
        return r;
    endfunction

    // The discard decision is taken on the first pair and held for the whole frame.
    always_comb begin
        wr_cnt_d      = wr_cnt_q;
        wr_bank_d     = wr_bank_q;
        discard_d     = discard_q;
        overflow_d    = overflow_q;
        discard_now   = discard_q;
        wr_en         = 1'b0;
        wr_frame_done = 1'b0;
        if (i_valid_in) begin
            if (wr_cnt_q == '0) begin
                discard_now = full_q[wr_bank_q];
                if (full_q[wr_bank_q]) begin
                    overflow_d = 1'b1;
                end
            end
            discard_d = discard_now;
            wr_en     = !discard_now;
            wr_cnt_d  = wr_cnt_q + ADDR_ONE;
            if ((wr_cnt_q == LAST_ADDR) && !discard_now) begin
                wr_frame_done = 1'b1;
                wr_bank_d     = ~wr_bank_q;
            end
        end
    end

    assign wr_addr = {wr_bank_q, bit_reverse(wr_cnt_q)};
    assign rd_addr = {rd_bank_q, rd_cnt_q};

    // Set and clear always target different banks, so both may land in one cycle.
    always_comb begin
        full_d = full_q;
        if (wr_frame_done) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (rd_issue && rd_last) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = (rd_issue && rd_last) ? ST_IDLE : ST_READ;
                end
            end
            ST_READ: begin
                if (rd_issue && rd_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // IDLE issues address 0 in the same cycle it sees a full bank, so frames stream without a bubble.
    always_comb begin
        fifo_pop  = (fifo_cnt_q != 2'd0) && i_ready;
        fifo_room = (fifo_cnt_q != 2'd2) || fifo_pop;
        rd_last   = (rd_cnt_q == LAST_ADDR);
        rd_issue  = 1'b0;
        case (state_q)
            ST_IDLE: rd_issue = full_q[rd_bank_q] && fifo_room;
            ST_READ: rd_issue = fifo_room;
            default: rd_issue = 1'b0;
        endcase
    end

    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        if (rd_issue) begin
            rd_cnt_d = rd_cnt_q + ADDR_ONE;
            if (rd_last) begin
                rd_bank_d = ~rd_bank_q;
            end
        end
    end

    always_comb begin
        fifo_cnt_d  = fifo_cnt_q;
        fifo_wptr_d = fifo_wptr_q;
        fifo_rptr_d = fifo_rptr_q;
        if (rd_issue) begin
            fifo_wptr_d = ~fifo_wptr_q;
        end
        if (fifo_pop) begin
            fifo_rptr_d = ~fifo_rptr_q;
        end
        case ({rd_issue, fifo_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            discard_q   <= 1'b0;
            overflow_q  <= 1'b0;
            full_q      <= 2'b00;
            state_q     <= ST_IDLE;
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            fifo_cnt_q  <= 2'd0;
            fifo_wptr_q <= 1'b0;
            fifo_rptr_q <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            discard_q   <= discard_d;
            overflow_q  <= overflow_d;
            full_q      <= full_d;
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_bank_q   <= rd_bank_d;
            fifo_cnt_q  <= fifo_cnt_d;
            fifo_wptr_q <= fifo_wptr_d;
            fifo_rptr_q <= fifo_rptr_d;
        end
    end

    // The RAM read register is the FIFO slot itself, giving one cycle from issue to visible data.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_lo[wr_addr] <= {i_data_a_real, i_data_a_imag};
            mem_hi[wr_addr] <= {i_data_b_real, i_data_b_imag};
        end
        if (rd_issue) begin
            fifo_lo[fifo_wptr_q]  <= mem_lo[rd_addr];
            fifo_hi[fifo_wptr_q]  <= mem_hi[rd_addr];
            fifo_sof[fifo_wptr_q] <= (rd_cnt_q == '0);
            fifo_eof[fifo_wptr_q] <= rd_last;
        end
    end

    always_comb begin
        o_valid_out   = (fifo_cnt_q != 2'd0);
        o_data_a_real = '0;
        o_data_a_imag = '0;
        o_data_b_real = '0;
        o_data_b_imag = '0;
        o_sof         = 1'b0;
        o_eof         = 1'b0;
        if (o_valid_out) begin
            o_data_a_real = fifo_lo[fifo_rptr_q][2*DW-1:DW];
            o_data_a_imag = fifo_lo[fifo_rptr_q][DW-1:0];
            o_data_b_real = fifo_hi[fifo_rptr_q][2*DW-1:DW];
            o_data_b_imag = fifo_hi[fifo_rptr_q][DW-1:0];
            o_sof         = fifo_sof[fifo_rptr_q];
            o_eof         = fifo_eof[fifo_rptr_q];
        end
    end

    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_fft_output_reorder.sv
// Directed bench for fft_output_reorder: N=16 instance for ordering, backpressure,
// overflow and reset scenarios, plus an N=1024 instance with a random-data scoreboard.
module tb_fft_output_reorder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, valid4, ready4;
    logic [31:0] ar4, ai4, br4, bi4;
    logic        ov4, osof4, oeof4, oovf4;
    logic [31:0] oar4, oai4, obr4, obi4;

    logic        rst10, valid10, ready10;
    logic [31:0] ar10, ai10, br10, bi10;
    logic        ov10, osof10, oeof10, oovf10;
    logic [31:0] oar10, oai10, obr10, obi10;

    fft_output_reorder #(.LOG2N(4), .DW(32)) dut4 (
        .i_clk(clk), .i_reset(rst4), .i_valid_in(valid4),
        .i_data_a_real(ar4), .i_data_a_imag(ai4),
        .i_data_b_real(br4), .i_data_b_imag(bi4),
        .i_ready(ready4), .o_valid_out(ov4),
        .o_data_a_real(oar4), .o_data_a_imag(oai4),
        .o_data_b_real(obr4), .o_data_b_imag(obi4),
        .o_sof(osof4), .o_eof(oeof4), .o_overflow(oovf4)
    );

    fft_output_reorder #(.LOG2N(10), .DW(32)) dut10 (
        .i_clk(clk), .i_reset(rst10), .i_valid_in(valid10),
        .i_data_a_real(ar10), .i_data_a_imag(ai10),
        .i_data_b_real(br10), .i_data_b_imag(bi10),
        .i_ready(ready10), .o_valid_out(ov10),
        .o_data_a_real(oar10), .o_data_a_imag(oai10),
        .o_data_b_real(obr10), .o_data_b_imag(obi10),
        .o_sof(osof10), .o_eof(oeof10), .o_overflow(oovf10)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int step_idx = 0;

    logic        s_valid, s_ready, s_sof, s_eof, s_ovf;
    logic [31:0] s_ar, s_ai, s_br, s_bi;
    logic        p_valid, p_ready, p_sof, p_eof;
    logic [31:0] p_ar, p_ai, p_br, p_bi;

    logic [31:0] cap_ar[$], cap_ai[$], cap_br[$], cap_bi[$];
    logic        cap_sof[$], cap_eof[$];
    int          cap_idx[$];

    int perm[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    logic [31:0] sb_ar[2048], sb_ai[2048], sb_br[2048], sb_bi[2048];

    function automatic int bitrev9(input int k);
        int r = 0;
        for (int i = 0; i < 9; i++) begin
            r = r | (((k >> i) & 1) << (8 - i));
        end
        return r;
    endfunction

    // One cycle on the N=16 instance: sample outputs, record accepted pairs, drive the next inputs.
    task automatic step4(input logic v, input logic [31:0] a, input logic rdy, input logic rst);
        @(negedge clk);
        p_valid = s_valid; p_ready = s_ready; p_sof = s_sof; p_eof = s_eof;
        p_ar = s_ar; p_ai = s_ai; p_br = s_br; p_bi = s_bi;
        ready4  = rdy;
        s_valid = ov4; s_ready = rdy; s_sof = osof4; s_eof = oeof4; s_ovf = oovf4;
        s_ar = oar4; s_ai = oai4; s_br = obr4; s_bi = obi4;
        if (s_valid && s_ready) begin
            cap_ar.push_back(s_ar); cap_ai.push_back(s_ai);
            cap_br.push_back(s_br); cap_bi.push_back(s_bi);
            cap_sof.push_back(s_sof); cap_eof.push_back(s_eof);
            cap_idx.push_back(step_idx);
        end
        rst4   = rst;
        valid4 = v;
        ar4    = v ? a : 32'd0;
        ai4    = v ? a + 32'd5000 : 32'd0;
        br4    = v ? a + 32'd100 : 32'd0;
        bi4    = v ? a + 32'd5100 : 32'd0;
        step_idx++;
    endtask

    task automatic clear_capture();
        cap_ar.delete(); cap_ai.delete(); cap_br.delete(); cap_bi.delete();
        cap_sof.delete(); cap_eof.delete(); cap_idx.delete();
        step_idx = 0;
    endtask

    task automatic do_reset();
        step4(1'b0, 32'd0, 1'b1, 1'b1);
        step4(1'b0, 32'd0, 1'b1, 1'b1);
        step4(1'b0, 32'd0, 1'b1, 1'b0);
        step4(1'b0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        step4(1'b0, 32'd0, 1'b1, 1'b1);
        step4(1'b0, 32'd0, 1'b1, 1'b1);
        n_cmp++;
        if (s_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_valid: got %b required 0", s_valid);
        end
        n_cmp++;
        if ({s_ar, s_ai, s_br, s_bi} !== 128'd0) begin
            n_fail++; $display("[TB] FAIL reset_data: got %h %h %h %h required all 0", s_ar, s_ai, s_br, s_bi);
        end
        n_cmp++;
        if ({s_sof, s_eof} !== 2'b00) begin
            n_fail++; $display("[TB] FAIL reset_sof_eof: got %b%b required 00", s_sof, s_eof);
        end
        n_cmp++;
        if (s_ovf !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_overflow: got %b required 0", s_ovf);
        end
        step4(1'b0, 32'd0, 1'b1, 1'b0);
        step4(1'b0, 32'd0, 1'b1, 1'b0);
        n_cmp++;
        if ({s_valid, s_ovf} !== 2'b00) begin
            n_fail++; $display("[TB] FAIL post_reset_idle: got valid=%b ovf=%b required 0 0", s_valid, s_ovf);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] sofv, eofv;
        logic [31:0] ea;
        do_reset();
        clear_capture();
        for (int p = 0; p < 8; p++) step4(1'b1, 32'(p), 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) step4(1'b0, 32'd0, 1'b1, 1'b0);
        n_cmp++;
        if (cap_ar.size() !== 8) begin
            n_fail++; $display("[TB] FAIL single_count: got %0d outputs required 8", cap_ar.size());
        end
        if (cap_idx.size() > 0) begin
            n_cmp++;
            if (cap_idx[0] !== 9) begin
                n_fail++; $display("[TB] FAIL single_latency: first output at cycle %0d required 9", cap_idx[0]);
            end
            n_cmp++;
            if (cap_idx[cap_idx.size()-1] !== 16) begin
                n_fail++; $display("[TB] FAIL single_last_cycle: last output at cycle %0d required 16", cap_idx[cap_idx.size()-1]);
            end
        end
        sofv = '0; eofv = '0;
        for (int k = 0; k < cap_ar.size() && k < 8; k++) begin
            ea = 32'(perm[k]);
            n_cmp++;
            if ({cap_ar[k], cap_ai[k], cap_br[k], cap_bi[k]} !== {ea, ea + 32'd5000, ea + 32'd100, ea + 32'd5100}) begin
                n_fail++;
                $display("[TB] FAIL single_data[%0d]: got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d", k,
                         cap_ar[k], cap_ai[k], cap_br[k], cap_bi[k], ea, ea + 5000, ea + 100, ea + 5100);
            end
            sofv[k] = cap_sof[k];
            eofv[k] = cap_eof[k];
        end
        n_cmp++;
        if (sofv !== 8'h01) begin
            n_fail++; $display("[TB] FAIL single_sof: got %b required 00000001", sofv);
        end
        n_cmp++;
        if (eofv !== 8'h80) begin
            n_fail++; $display("[TB] FAIL single_eof: got %b required 10000000", eofv);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ea;
        do_reset();
        clear_capture();
        for (int i = 0; i < 16; i++) step4(1'b1, (i < 8) ? 32'(i) : 32'(i + 2), 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step4(1'b0, 32'd0, 1'b1, 1'b0);
        n_cmp++;
        if (cap_ar.size() !== 16) begin
            n_fail++; $display("[TB] FAIL b2b_count: got %0d outputs required 16", cap_ar.size());
        end
        if (cap_idx.size() > 0) begin
            n_cmp++;
            if ({cap_idx[0], cap_idx[cap_idx.size()-1]} !== {32'd9, 32'd24}) begin
                n_fail++; $display("[TB] FAIL b2b_span: cycles %0d..%0d required 9..24", cap_idx[0], cap_idx[cap_idx.size()-1]);
            end
        end
        for (int k = 0; k < cap_ar.size() && k < 16; k++) begin
            ea = 32'(((k < 8) ? 0 : 10) + perm[k % 8]);
            n_cmp++;
            if ({cap_ar[k], cap_br[k], cap_sof[k], cap_eof[k]} !== {ea, ea + 32'd100, (k % 8) == 0, (k % 8) == 7}) begin
                n_fail++;
                $display("[TB] FAIL b2b_data[%0d]: got a=%0d b=%0d sof=%b eof=%b required a=%0d b=%0d", k,
                         cap_ar[k], cap_br[k], cap_sof[k], cap_eof[k], ea, ea + 100);
            end
        end
        n_cmp++;
        if (s_ovf !== 1'b0) begin
            n_fail++; $display("[TB] FAIL b2b_overflow: got %b required 0", s_ovf);
        end
    endtask

    task automatic test_backpressure();
        logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] ea;
        int stalls = 0;
        do_reset();
        clear_capture();
        for (int i = 0; i < 76; i++) begin
            step4(i < 16, (i < 8) ? 32'(i) : 32'(i + 2), pat[step_idx % 4], 1'b0);
            if (p_valid && !p_ready) begin
                stalls++;
                n_cmp++;
                if ({s_valid, s_ar, s_ai, s_br, s_bi, s_sof, s_eof} !== {1'b1, p_ar, p_ai, p_br, p_bi, p_sof, p_eof}) begin
                    n_fail++;
                    $display("[TB] FAIL bp_stable@%0d: got v=%b a=%0d b=%0d required v=1 a=%0d b=%0d", i,
                             s_valid, s_ar, s_br, p_ar, p_br);
                end
            end
        end
        n_cmp++;
        if (cap_ar.size() !== 16) begin
            n_fail++; $display("[TB] FAIL bp_count: got %0d outputs required 16", cap_ar.size());
        end
        for (int k = 0; k < cap_ar.size() && k < 16; k++) begin
            ea = 32'(((k < 8) ? 0 : 10) + perm[k % 8]);
            n_cmp++;
            if ({cap_ar[k], cap_bi[k], cap_sof[k], cap_eof[k]} !== {ea, ea + 32'd5100, (k % 8) == 0, (k % 8) == 7}) begin
                n_fail++;
                $display("[TB] FAIL bp_data[%0d]: got a=%0d bi=%0d required a=%0d bi=%0d", k,
                         cap_ar[k], cap_bi[k], ea, ea + 5100);
            end
        end
        n_cmp++;
        if ({s_ovf, (stalls > 0)} !== 2'b01) begin
            n_fail++; $display("[TB] FAIL bp_overflow_stalls: got ovf=%b stalls=%0d required ovf=0 stalls>0", s_ovf, stalls);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] ea;
        do_reset();
        clear_capture();
        for (int i = 0; i < 16; i++) step4(1'b1, 32'(10 * (i / 8) + (i % 8)), 1'b0, 1'b0);
        step4(1'b1, 32'd20, 1'b0, 1'b0);
        n_cmp++;
        if (s_ovf !== 1'b0) begin
            n_fail++; $display("[TB] FAIL ovf_early: got %b required 0 before third frame", s_ovf);
        end
        for (int i = 1; i < 8; i++) step4(1'b1, 32'(20 + i), 1'b0, 1'b0);
        step4(1'b0, 32'd0, 1'b0, 1'b0);
        step4(1'b0, 32'd0, 1'b0, 1'b0);
        n_cmp++;
        if ({s_ovf, s_valid} !== 2'b11) begin
            n_fail++; $display("[TB] FAIL ovf_set: got ovf=%b valid=%b required 1 1", s_ovf, s_valid);
        end
        n_cmp++;
        if (cap_ar.size() !== 0) begin
            n_fail++; $display("[TB] FAIL ovf_no_accept: got %0d accepted required 0", cap_ar.size());
        end
        for (int i = 0; i < 40; i++) step4(1'b0, 32'd0, 1'b1, 1'b0);
        n_cmp++;
        if (cap_ar.size() !== 16) begin
            n_fail++; $display("[TB] FAIL ovf_drain_count: got %0d outputs required 16", cap_ar.size());
        end
        for (int k = 0; k < cap_ar.size() && k < 16; k++) begin
            ea = 32'(((k < 8) ? 0 : 10) + perm[k % 8]);
            n_cmp++;
            if ({cap_ar[k], cap_br[k], cap_sof[k], cap_eof[k]} !== {ea, ea + 32'd100, (k % 8) == 0, (k % 8) == 7}) begin
                n_fail++;
                $display("[TB] FAIL ovf_data[%0d]: got a=%0d b=%0d required a=%0d b=%0d", k,
                         cap_ar[k], cap_br[k], ea, ea + 100);
            end
        end
        n_cmp++;
        if (s_ovf !== 1'b1) begin
            n_fail++; $display("[TB] FAIL ovf_sticky: got %b required 1", s_ovf);
        end
    endtask

    // Runs straight after test_overflow so the sticky flag is set when reset hits.
    task automatic test_reset_mid_frame();
        logic [31:0] ea;
        clear_capture();
        for (int p = 0; p < 5; p++) step4(1'b1, 32'(50 + p), 1'b1, 1'b0);
        step4(1'b0, 32'd0, 1'b1, 1'b1);
        step4(1'b0, 32'd0, 1'b1, 1'b1);
        n_cmp++;
        if ({s_valid, s_sof, s_eof, s_ovf} !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL midreset_flags: got v=%b sof=%b eof=%b ovf=%b required 0 0 0 0", s_valid, s_sof, s_eof, s_ovf);
        end
        n_cmp++;
        if ({s_ar, s_ai, s_br, s_bi} !== 128'd0) begin
            n_fail++; $display("[TB] FAIL midreset_data: got %h %h %h %h required all 0", s_ar, s_ai, s_br, s_bi);
        end
        step4(1'b0, 32'd0, 1'b1, 1'b0);
        clear_capture();
        for (int p = 0; p < 8; p++) step4(1'b1, 32'(30 + p), 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step4(1'b0, 32'd0, 1'b1, 1'b0);
        n_cmp++;
        if (cap_ar.size() !== 8) begin
            n_fail++; $display("[TB] FAIL midreset_count: got %0d outputs required 8", cap_ar.size());
        end
        if (cap_idx.size() > 0) begin
            n_cmp++;
            if (cap_idx[0] !== 9) begin
                n_fail++; $display("[TB] FAIL midreset_latency: first output at cycle %0d required 9", cap_idx[0]);
            end
        end
        for (int k = 0; k < cap_ar.size() && k < 8; k++) begin
            ea = 32'(30 + perm[k]);
            n_cmp++;
            if ({cap_ar[k], cap_ai[k], cap_sof[k], cap_eof[k]} !== {ea, ea + 32'd5000, k == 0, k == 7}) begin
                n_fail++;
                $display("[TB] FAIL midreset_data[%0d]: got a=%0d ai=%0d required a=%0d ai=%0d", k,
                         cap_ar[k], cap_ai[k], ea, ea + 5000);
            end
        end
        n_cmp++;
        if (s_ovf !== 1'b0) begin
            n_fail++; $display("[TB] FAIL midreset_overflow: got %b required 0", s_ovf);
        end
    endtask

    task automatic test_large_random();
        int err[4] = '{0, 0, 0, 0};
        int first_bad[4] = '{0, 0, 0, 0};
        int n_out = 0;
        int f, k, idx;
        for (int i = 0; i < 2048; i++) begin
            sb_ar[i] = $urandom; sb_ai[i] = $urandom;
            sb_br[i] = $urandom; sb_bi[i] = $urandom;
        end
        @(negedge clk); rst10 = 1'b1; ready10 = 1'b1;
        @(negedge clk);
        @(negedge clk); rst10 = 1'b0;
        for (int c = 0; c < 2048 + 600; c++) begin
            @(negedge clk);
            if (ov10) begin
                if (n_out < 2048) begin
                    f = n_out / 512;
                    k = n_out % 512;
                    idx = f * 512 + bitrev9(k);
                    if ({oar10, oai10, obr10, obi10, osof10, oeof10} !==
                        {sb_ar[idx], sb_ai[idx], sb_br[idx], sb_bi[idx], k == 0, k == 511}) begin
                        if (err[f] == 0) first_bad[f] = k;
                        err[f]++;
                    end
                end
                n_out++;
            end
            valid10 = (c < 2048);
            ar10 = (c < 2048) ? sb_ar[c % 2048] : 32'd0;
            ai10 = (c < 2048) ? sb_ai[c % 2048] : 32'd0;
            br10 = (c < 2048) ? sb_br[c % 2048] : 32'd0;
            bi10 = (c < 2048) ? sb_bi[c % 2048] : 32'd0;
        end
        n_cmp++;
        if (n_out !== 2048) begin
            n_fail++; $display("[TB] FAIL large_count: got %0d outputs required 2048", n_out);
        end
        for (int fr = 0; fr < 4; fr++) begin
            n_cmp++;
            if (err[fr] !== 0) begin
                n_fail++; $display("[TB] FAIL large_frame%0d: got %0d bad pairs (first k=%0d) required 0", fr, err[fr], first_bad[fr]);
            end
        end
        n_cmp++;
        if (oovf10 !== 1'b0) begin
            n_fail++; $display("[TB] FAIL large_overflow: got %b required 0", oovf10);
        end
    endtask

    initial begin
        rst4 = 1'b0; valid4 = 1'b0; ready4 = 1'b0;
        ar4 = '0; ai4 = '0; br4 = '0; bi4 = '0;
        rst10 = 1'b0; valid10 = 1'b0; ready10 = 1'b1;
        ar10 = '0; ai10 = '0; br10 = '0; bi10 = '0;
        s_valid = 1'b0; s_ready = 1'b0; s_sof = 1'b0; s_eof = 1'b0; s_ovf = 1'b0;
        s_ar = '0; s_ai = '0; s_br = '0; s_bi = '0;
        p_valid = 1'b0; p_ready = 1'b0; p_sof = 1'b0; p_eof = 1'b0;
        p_ar = '0; p_ai = '0; p_br = '0; p_bi = '0;

        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_mid_frame();
        test_large_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
